// File: rtl/obi_pkg.sv
// Shared types and widths for the OBI arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package obi_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    localparam int unsigned OBI_ATOP_W = 6;
    localparam int unsigned OBI_BE_W   = 4;

endpackage

// File: rtl/obi_id_fifo.sv
// Small FIFO of requester IDs for granted-but-unanswered OBI transactions.
// Latency: push visible at head on the next cycle; head/full/empty/count are registered.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
//
// Ports: clk/rst (sync active-high), push_i/push_dat_i write side,
//        pop_i read side, head_o oldest entry, full_o/empty_o/count_o occupancy.
module obi_id_fifo
    import obi_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned W     = 1,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    // Explicit wrap so non-power-of-two depths (and DEPTH=1) also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/obi_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between fetch (m0) and load/store (m1).
// Latency: zero-cycle combinational request, grant and response paths.
// Backpressure: selection locked until granted; requests blocked while MAX_OUTSTANDING are in flight.
//
// Ports: clk/rst (sync active-high); mN_* requester-side address and response phases;
//        obi_* shared memory-side address phase (req/addr/we/be/wdata/atop, gnt)
//        and response phase (rvalid/rdata/err).
module obi_arbiter
    import obi_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [WIDTH-1:0]      m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [OBI_BE_W-1:0]   m0_be_i,
    input  logic [WIDTH-1:0]      m0_wdata_i,
    input  logic [OBI_ATOP_W-1:0] m0_atop_i,
    output logic                  m0_rvalid_o,
    output logic [WIDTH-1:0]      m0_rdata_o,
    output logic                  m0_err_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [WIDTH-1:0]      m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [OBI_BE_W-1:0]   m1_be_i,
    input  logic [WIDTH-1:0]      m1_wdata_i,
    input  logic [OBI_ATOP_W-1:0] m1_atop_i,
    output logic                  m1_rvalid_o,
    output logic [WIDTH-1:0]      m1_rdata_o,
    output logic                  m1_err_o,

    output logic                  obi_req_o,
    output logic [WIDTH-1:0]      obi_addr_o,
    output logic                  obi_we_o,
    output logic [OBI_BE_W-1:0]   obi_be_o,
    output logic [WIDTH-1:0]      obi_wdata_o,
    output logic [OBI_ATOP_W-1:0] obi_atop_o,
    input  logic                  obi_gnt_i,
    input  logic                  obi_rvalid_i,
    input  logic [WIDTH-1:0]      obi_rdata_i,
    input  logic                  obi_err_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t state_q, state_d;
    logic       sel_q, sel_d;     // requester locked while in ARB_HOLD
    logic       prio_q, prio_d;   // favoured requester on a tie
    logic       sel;
    logic       sel_req;
    logic       handshake;
    logic       resp_vld;

    logic             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt_unused; // occupancy already covered by full/empty; kept for debug

    // Selection and FSM. obi_req_o is gated by the registered full flag only,
    // so a response in this cycle never frees a slot for this cycle's request.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        sel     = sel_q;

        if (state_q == ARB_IDLE) begin
            if (m0_req_i && m1_req_i) begin
                sel = prio_q;
            end else begin
                sel = m1_req_i;
            end
        end

        sel_req   = sel ? m1_req_i : m0_req_i;
        obi_req_o = sel_req & ~fifo_full;
        handshake = obi_req_o & obi_gnt_i;

        case (state_q)
            ARB_IDLE: begin
                if (obi_req_o && !obi_gnt_i) begin
                    state_d = ARB_HOLD;
                    sel_d   = sel;
                end
            end
            ARB_HOLD: begin
                // Release on handshake, or if the locked requester withdraws.
                if (handshake || !sel_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (handshake) begin
            prio_d = ~sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
        end
    end

    // Address phase: muxed from the selection, forced to zero when not requesting.
    always_comb begin
        obi_addr_o  = '0;
        obi_we_o    = 1'b0;
        obi_be_o    = '0;
        obi_wdata_o = '0;
        obi_atop_o  = '0;
        if (obi_req_o) begin
            obi_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            obi_we_o    = sel ? m1_we_i    : m0_we_i;
            obi_be_o    = sel ? m1_be_i    : m0_be_i;
            obi_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
            obi_atop_o  = sel ? m1_atop_i  : m0_atop_i;
        end
    end

    assign m0_gnt_o = handshake & ~sel;
    assign m1_gnt_o = handshake &  sel;

    // Responses are in order; unexpected ones (nothing outstanding) are dropped.
    assign resp_vld    = obi_rvalid_i & ~fifo_empty;
    assign m0_rvalid_o = resp_vld & ~fifo_head;
    assign m1_rvalid_o = resp_vld &  fifo_head;
    assign m0_rdata_o  = m0_rvalid_o ? obi_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? obi_rdata_i : '0;
    assign m0_err_o    = m0_rvalid_o & obi_err_i;
    assign m1_err_o    = m1_rvalid_o & obi_err_i;

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (1)
    ) u_id_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (handshake),
        .push_dat_i (sel),
        .pop_i      (resp_vld),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt_unused)
    );

endmodule

// File: tb/tb_obi_arbiter.sv
module tb_obi_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0200;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] WD0 = 32'hA0A0_A0A0;
    localparam logic [31:0] WD1 = 32'hB1B1_B1B1;
    localparam logic [3:0]  BE0 = 4'hF;
    localparam logic [3:0]  BE1 = 4'h3;
    localparam logic [5:0]  AT0 = 6'h00;
    localparam logic [5:0]  AT1 = 6'h21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic        m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [5:0]  m0_atop_i, m1_atop_i;
    logic        m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        obi_req_o, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic [3:0]  obi_be_o;
    logic [5:0]  obi_atop_o;
    logic        obi_gnt_i = 1'b0, obi_rvalid_i = 1'b0, obi_err_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign m0_addr_i = A0;  assign m1_addr_i = A1;
    assign m0_we_i = 1'b0;  assign m1_we_i = 1'b1;
    assign m0_be_i = BE0;   assign m1_be_i = BE1;
    assign m0_wdata_i = WD0; assign m1_wdata_i = WD1;
    assign m0_atop_i = AT0; assign m1_atop_i = AT1;

    obi_arbiter #(.WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_atop_i(m0_atop_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_atop_i(m1_atop_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
        .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_atop_o(obi_atop_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .obi_err_i(obi_err_i)
    );

    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_req;
        logic        e_sel;
        logic        e_g0;
        logic        e_g1;
        logic        e_rv0;
        logic        e_rv1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rs, r0, r1, g, rv, input logic [31:0] rd,
                                input logic er, eq, es, g0, g1, v0, v1);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.r1 = r1; v.gnt = g; v.rv = rv; v.rdata = rd; v.err = er;
        v.e_req = eq; v.e_sel = es; v.e_g0 = g0; v.e_g1 = g1; v.e_rv0 = v0; v.e_rv1 = v1;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic check_row(input int row, input vec_t v);
        chk("obi_req",   row, 32'(obi_req_o),   32'(v.e_req));
        chk("obi_addr",  row, obi_addr_o,  v.e_req ? (v.e_sel ? A1 : A0) : 32'h0);
        chk("obi_we",    row, 32'(obi_we_o),    v.e_req ? 32'(v.e_sel) : 32'h0);
        chk("obi_be",    row, 32'(obi_be_o),    v.e_req ? 32'(v.e_sel ? BE1 : BE0) : 32'h0);
        chk("obi_wdata", row, obi_wdata_o, v.e_req ? (v.e_sel ? WD1 : WD0) : 32'h0);
        chk("obi_atop",  row, 32'(obi_atop_o),  v.e_req ? 32'(v.e_sel ? AT1 : AT0) : 32'h0);
        chk("m0_gnt",    row, 32'(m0_gnt_o),    32'(v.e_g0));
        chk("m1_gnt",    row, 32'(m1_gnt_o),    32'(v.e_g1));
        chk("m0_rvalid", row, 32'(m0_rvalid_o), 32'(v.e_rv0));
        chk("m1_rvalid", row, 32'(m1_rvalid_o), 32'(v.e_rv1));
        chk("m0_rdata",  row, m0_rdata_o,  v.e_rv0 ? v.rdata : 32'h0);
        chk("m1_rdata",  row, m1_rdata_o,  v.e_rv1 ? v.rdata : 32'h0);
        chk("m0_err",    row, 32'(m0_err_o),    v.e_rv0 ? 32'(v.err) : 32'h0);
        chk("m1_err",    row, 32'(m1_err_o),    v.e_rv1 ? 32'(v.err) : 32'h0);
    endtask

    initial begin
        //                rst r0 r1 gnt rv rdata         err  req sel g0 g1 rv0 rv1
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 0, 0)); // 0 reset
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 0)); // 1 m1 single
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hDEADBEEF, 0,   0, 0, 0, 0, 0, 1)); // 2 resp m1
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 0, 0)); // 3 reset
        vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 0)); // 4 both: m1
        vecs.push_back(mk(0, 1, 1, 1, 1, 32'h11111111, 0,   1, 0, 1, 0, 0, 1)); // 5 m0, resp m1
        vecs.push_back(mk(0, 1, 1, 1, 1, 32'h22222222, 1,   1, 1, 0, 1, 1, 0)); // 6 m1, resp m0 err
        vecs.push_back(mk(0, 1, 1, 1, 1, 32'h33333333, 0,   1, 0, 1, 0, 0, 1)); // 7 m0, resp m1
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h44444444, 0,   0, 0, 0, 0, 1, 0)); // 8 resp m0
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0,   1, 0, 0, 0, 0, 0)); // 9 m0 waits
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,        0,   1, 0, 0, 0, 0, 0)); // 10 hold m0
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,        0,   1, 0, 0, 0, 0, 0)); // 11 hold m0
        vecs.push_back(mk(0, 1, 1, 1, 0, 32'h0,        0,   1, 0, 1, 0, 0, 0)); // 12 m0 granted
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 0)); // 13 m1 next, full
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,        0,   0, 0, 0, 0, 0, 0)); // 14 blocked
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'h55555555, 0,   0, 0, 0, 0, 1, 0)); // 15 blocked, resp m0
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'h66666666, 0,   1, 0, 1, 0, 0, 1)); // 16 reassert + resp
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h77777777, 0,   0, 0, 0, 0, 1, 0)); // 17 resp m0
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h88888888, 0,   0, 0, 0, 0, 0, 0)); // 18 stray dropped
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,        0,   1, 0, 1, 0, 0, 0)); // 19
        vecs.push_back(mk(0, 0, 1, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 0)); // 20 full again
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,        0,   0, 0, 0, 0, 0, 0)); // 21 blocked
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'hAAAAAAAA, 0,   0, 0, 0, 0, 1, 0)); // 22 resp m0
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0,   1, 0, 0, 0, 0, 0)); // 23 into hold
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 0, 0)); // 24 reset mid-txn
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h99999999, 0,   1, 1, 0, 0, 0, 0)); // 25 prio=1, resp dropped
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 0, 0)); // 26 locked m1 drops
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,        0,   1, 0, 1, 0, 0, 0)); // 27 back to idle

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; m0_req_i = vecs[i].r0; m1_req_i = vecs[i].r1;
            obi_gnt_i = vecs[i].gnt; obi_rvalid_i = vecs[i].rv;
            obi_rdata_i = vecs[i].rdata; obi_err_i = vecs[i].err;
            #1;
            check_row(i, vecs[i]);
        end

        // Back-to-back: one m0 transaction outstanding, push and pop every cycle.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            m0_req_i = 1'b1; m1_req_i = 1'b0; obi_gnt_i = 1'b1;
            obi_rvalid_i = 1'b1; obi_rdata_i = 32'h1000 + 32'(k); obi_err_i = 1'b0;
            #1;
            chk("b2b_req",    100 + k, 32'(obi_req_o),   32'h1);
            chk("b2b_gnt0",   100 + k, 32'(m0_gnt_o),    32'h1);
            chk("b2b_rv0",    100 + k, 32'(m0_rvalid_o), 32'h1);
            chk("b2b_rdata0", 100 + k, m0_rdata_o,       32'h1000 + 32'(k));
        end

        // Drain the last one, then a stray response must be dropped.
        @(negedge clk);
        m0_req_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h2000;
        #1;
        chk("drain_rv0",   200, 32'(m0_rvalid_o), 32'h1);
        chk("drain_rdata", 200, m0_rdata_o,       32'h2000);
        @(negedge clk);
        obi_rdata_i = 32'h3000;
        #1;
        chk("stray_rv0", 201, 32'(m0_rvalid_o), 32'h0);
        chk("stray_rv1", 201, 32'(m1_rvalid_o), 32'h0);
        @(negedge clk);
        obi_rvalid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_arbiter.md
# obi_arbiter

Two-requester arbiter sharing one OBI manager port between the core's instruction-fetch path (requester 0) and load/store path (requester 1). It sits between the two per-path OBI controllers and the single memory-side OBI bus. It selects one address phase at a time and holds the selection stable until it is granted. It records the ID of every granted transaction and routes in-order responses back to the originating requester.

## Interface
- WIDTH, 32, address/data width
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (power of two, ≥1)
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- mN_req_i  input  1  requester N (N=0,1) address-phase request
- mN_gnt_o  output  1  requester N grant
- mN_addr_i  input  WIDTH  requester N address
- mN_we_i  input  1  requester N write enable
- mN_be_i  input  4  requester N byte enables
- mN_wdata_i  input  WIDTH  requester N write data
- mN_atop_i  input  6  requester N atomic op
- mN_rvalid_o  output  1  requester N response valid
- mN_rdata_o  output  WIDTH  requester N read data
- mN_err_o  output  1  requester N response error
- obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_atop_o  output  1/WIDTH/1/4/WIDTH/6  shared address phase
- obi_gnt_i  input  1  shared grant
- obi_rvalid_i, obi_rdata_i, obi_err_i  input  1/WIDTH/1  shared response phase

## Operation
- FSM states: ARB_IDLE, ARB_HOLD. Reset state: ARB_IDLE.
- ARB_IDLE:
  - sel = round-robin winner among asserted mN_req_i.
  - Priority bit `prio` names the favoured requester. Reset value 1 (load/store first).
  - If only one requester is asserted, it wins.
- obi_req_o = selected mN_req_i AND (count != MAX_OUTSTANDING).
  - count is the registered outstanding counter.
  - A same-cycle rvalid does not free a slot for this cycle's request.
- Address-phase outputs mux from the selected requester. All address-phase outputs are 0 when obi_req_o=0.
- mN_gnt_o = obi_gnt_i & obi_req_o & (sel==N). Combinational; the non-selected requester sees gnt=0.
- ARB_IDLE → ARB_HOLD when obi_req_o=1 and obi_gnt_i=0. The locked sel is registered.
- ARB_HOLD:
  - sel = locked value, regardless of the other requester.
  - → ARB_IDLE on handshake (obi_req_o & obi_gnt_i).
  - If the locked requester drops its req (protocol violation), → ARB_IDLE with no handshake.
- On every handshake:
  - push sel into the ID FIFO;
  - count++;
  - prio ← ~sel.
- On obi_rvalid_i with count>0:
  - route to requester = FIFO head: rvalid/rdata/err;
  - pop the head; count--.
- Simultaneous push and pop: count unchanged, FIFO advances both pointers.
- obi_rvalid_i with count==0: dropped. No requester sees rvalid.
- Non-addressed requester's response outputs: rvalid=0, rdata=0, err=0.
- Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Reset values: every output 0; FIFO empty; count=0; prio=1; state ARB_IDLE.
- Request path is zero-latency combinational: mN_req_i → obi_req_o, obi_gnt_i → mN_gnt_o.
- Response path is zero-latency combinational: obi_rvalid_i → mN_rvalid_o, in the same cycle.
- No combinational path from obi_rvalid_i to obi_req_o.
- Back-to-back handshakes allowed every cycle while count < MAX_OUTSTANDING.
- Reset mid-transaction clears all state. Responses arriving after reset are dropped as unexpected.

## Structure
- Shared package obi_pkg holds:
  - arb_state_t {ARB_IDLE, ARB_HOLD};
  - localparam OBI_ATOP_W=6;
  - localparam OBI_BE_W=4.
- One sub-module, obi_id_fifo:
  - parameters DEPTH and W=1;
  - push/pop/head/full/empty/count;
  - synchronous active-high reset.
  - It supplies count and full to the arbiter.

## Test plan
- Reset, then m1_req_i=1, addr=0x100, obi_gnt_i=1 → obi_addr_o=0x100, m1_gnt_o=1, m0_gnt_o=0. Next cycle obi_rvalid_i=1, rdata=0xDEADBEEF → m1_rvalid_o=1, m1_rdata_o=0xDEADBEEF.
- Both requesters asserted continuously with gnt=1 for 4 cycles → grants alternate m1, m0, m1, m0. Responses return in that order with distinct rdata, and each is routed correctly.
- m0 requests with obi_gnt_i=0 for 3 cycles, m1 asserts in cycle 2 → obi_addr_o stays m0's address and m0_gnt_o rises only when gnt=1. m1 is granted next.
- MAX_OUTSTANDING=2, two grants with no rvalid → obi_req_o=0 despite m0_req_i=1. rvalid in the following cycle → obi_req_o reasserts one cycle later.
- obi_rvalid_i=1 with count=0 → both mN_rvalid_o stay 0; count stays 0.
- rst=1 for one cycle while in ARB_HOLD with 1 outstanding → all outputs 0, state ARB_IDLE, count 0, prio=1.
